echo_delay: RTL and testbench

- Feedback echo (delay-line) effect stage that sits directly downstream of the bitcrusher in the drum audio chain.
- Consumes one signed 12-bit sample per start pulse, which is the bitcrusher's done/modified_sample.
- Mixes the sample with an attenuated copy read from a circular buffer `delay_len` samples back, and writes the mixed result back into the buffer.
- Emits the result with a one-cycle done pulse toward the DAC/PWM output stage.

---
 rtl/audio_fx_pkg.sv | 19 +
 rtl/echo_delay_ram.sv | 28 ++
 rtl/echo_delay.sv | 160 ++++++++++++++++
 tb/tb_echo_delay.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the drum audio effect chain (bitcrusher -> echo_delay -> DAC).
// Holds the sample format and the echo stage's state encoding.
package audio_fx_pkg;

    localparam int SAMPLE_WIDTH = 12;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = 12'sd2047;
    localparam sample_t SAMPLE_MIN = -12'sd2048;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_MIX   = 2'd3
    } echo_state_t;

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay buffer: one write port, one registered read port.
// Contents are not reset; the owning stage clears them explicitly.
module echo_delay_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write on an address collision: the old word is returned.
    always_ff @(posedge clock) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/echo_delay.sv
// Feedback echo stage: mixes each dry sample with an attenuated copy from
// delay_len samples back, stores the saturated mix, and emits it with a done pulse.
module echo_delay
    import audio_fx_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         enable,
    input  logic [ADDR_WIDTH-1:0]        delay_len,
    input  logic [2:0]                   fb_shift,
    input  logic signed [DATA_WIDTH-1:0] incoming_sample,
    output logic signed [DATA_WIDTH-1:0] modified_sample,
    output logic                         done,
    output logic                         ready
);

    // Handshake: start is a one-cycle valid strobe that is accepted only on an
    // edge where ready=1; any other start is dropped (no queuing). done is a
    // one-cycle strobe marking the edge on which modified_sample changed.

    localparam logic [ADDR_WIDTH-1:0]        LAST_ADDR = '1;
    localparam logic signed [DATA_WIDTH:0]   SAT_MAX   = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0]   SAT_MIN   = {2'b11, {(DATA_WIDTH-1){1'b0}}};

    echo_state_t state;
    echo_state_t next_state;

    logic [ADDR_WIDTH-1:0]        clear_addr;
    logic [ADDR_WIDTH-1:0]        wr_ptr;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic signed [DATA_WIDTH-1:0] dry_q;
    logic                         enable_q;
    logic [2:0]                   shift_q;

    logic signed [DATA_WIDTH-1:0] delayed;
    logic signed [DATA_WIDTH-1:0] wet;
    logic signed [DATA_WIDTH:0]   sum;
    logic signed [DATA_WIDTH-1:0] sat;

    logic                         ram_we;
    logic [ADDR_WIDTH-1:0]        ram_waddr;
    logic [DATA_WIDTH-1:0]        ram_wdata;
    logic [DATA_WIDTH-1:0]        ram_rdata;

    echo_delay_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign delayed = ram_rdata;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (clear_addr == LAST_ADDR) next_state = ST_IDLE;
            ST_IDLE:  if (start) next_state = ST_READ;
            ST_READ:  next_state = ST_MIX;
            ST_MIX:   next_state = ST_IDLE;
            default:  next_state = ST_CLEAR;
        endcase
    end

    // Output logic: buffer write port is owned by CLEAR (zero fill) and MIX (feedback store)
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = sat;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clear_addr;
                ram_wdata = '0;
            end
            ST_MIX: begin
                ram_we    = 1'b1;
                ram_waddr = wr_ptr;
                ram_wdata = sat;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // Mix path: the sum is one bit wider so overflow is visible before clamping
    always_comb begin
        wet = '0;
        if (enable_q && (shift_q != 3'd0)) begin
            wet = delayed >>> shift_q;
        end
        sum = {dry_q[DATA_WIDTH-1], dry_q} + {wet[DATA_WIDTH-1], wet};
        if (sum > SAT_MAX) begin
            sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat = sum[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clear_addr      <= '0;
            wr_ptr          <= '0;
            rd_addr         <= '0;
            dry_q           <= '0;
            enable_q        <= 1'b0;
            shift_q         <= 3'd0;
            modified_sample <= '0;
            done            <= 1'b0;
            ready           <= 1'b0;
        end else begin
            done  <= 1'b0;
            ready <= (next_state == ST_IDLE);
            case (state)
                ST_CLEAR: begin
                    clear_addr <= clear_addr + 1'b1;
                end
                ST_IDLE: begin
                    if (start) begin
                        dry_q    <= incoming_sample;
                        enable_q <= enable;
                        shift_q  <= fb_shift;
                        rd_addr  <= wr_ptr - delay_len;
                    end
                end
                ST_MIX: begin
                    modified_sample <= sat;
                    done            <= 1'b1;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay with a 16-deep buffer: clear timing, bypass,
// feedback chain, saturation, pointer wrap and start/reset robustness.
module tb_echo_delay;

    localparam int AW = 4;
    localparam int DW = 12;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 enable;
    logic [AW-1:0]        delay_len;
    logic [2:0]           fb_shift;
    logic signed [DW-1:0] incoming_sample;
    logic signed [DW-1:0] modified_sample;
    logic                 done;
    logic                 ready;

    int checks   = 0;
    int failures = 0;

    echo_delay #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .enable          (enable),
        .delay_len       (delay_len),
        .fb_shift        (fb_shift),
        .incoming_sample (incoming_sample),
        .modified_sample (modified_sample),
        .done            (done),
        .ready           (ready)
    );

    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------

    task automatic pulse_reset(output logic r_ready, output logic r_done, output int r_mod);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1;
        r_ready = ready;
        r_done  = done;
        r_mod   = modified_sample;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int n, output int dones);
        n = 0;
        dones = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #1;
            n++;
            if (done) dones++;
            if (ready) break;
        end
    endtask

    task automatic send_sample(input int s, output int res, output int lat);
        int w;
        w   = 0;
        lat = -1;
        res = 0;
        @(negedge clock);
        while (!ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!ready) return;
        start = 1'b1;
        incoming_sample = DW'(s);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = k;
                res = modified_sample;
                break;
            end
        end
    endtask

    task automatic fresh_start();
        logic r_ready, r_done;
        int   r_mod, n, d;
        pulse_reset(r_ready, r_done, r_mod);
        wait_ready(n, d);
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        logic r_ready, r_done;
        int   r_mod, n, dones;
        pulse_reset(r_ready, r_done, r_mod);
        checks++; if (r_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0b want 0", r_ready); end
        checks++; if (r_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", r_done); end
        checks++; if (r_mod !== 0) begin failures++; $display("FAIL reset_sample: got %0d want 0", r_mod); end
        n = 0;
        dones = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            n++;
            if (done) dones++;
        end
        @(negedge clock);
        start = 1'b1;
        incoming_sample = 12'sh055;
        @(posedge clock);
        #1;
        n++;
        if (done) dones++;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            #1;
            n++;
            if (done) dones++;
            if (ready) break;
        end
        repeat (5) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL clear_cycles: got %0d want 16", n); end
        checks++; if (dones !== 0) begin failures++; $display("FAIL clear_start_dropped: got %0d dones want 0", dones); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL idle_ready: got %0b want 1", ready); end
    endtask

    task automatic test_bypass();
        int res, lat;
        fresh_start();
        enable = 1'b1; delay_len = 4'd1; fb_shift = 3'd1;
        send_sample(500, res, lat);
        checks++; if (res !== 500) begin failures++; $display("FAIL bypass_prime: got %0d want 500", res); end
        enable = 1'b0;
        send_sample(12'h123, res, lat);
        checks++; if (res !== 12'h123) begin failures++; $display("FAIL bypass_value: got %0d want %0d", res, 12'h123); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL bypass_latency: got %0d want 2", lat); end
        @(posedge clock);
        #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL bypass_done_single: got %0b want 0", done); end
    endtask

    task automatic test_echo_chain();
        int exp_chain [13] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
        int res, lat;
        fresh_start();
        enable = 1'b1; delay_len = 4'd4; fb_shift = 3'd1;
        for (int i = 0; i < 13; i++) begin
            send_sample((i == 0) ? 1000 : 0, res, lat);
            checks++; if (res !== exp_chain[i]) begin failures++; $display("FAIL echo_chain[%0d]: got %0d want %0d", i, res, exp_chain[i]); end
            checks++; if (lat !== 2) begin failures++; $display("FAIL echo_latency[%0d]: got %0d want 2", i, lat); end
        end
        fresh_start();
        delay_len = 4'd1; fb_shift = 3'd1;
        send_sample(-1001, res, lat);
        checks++; if (res !== -1001) begin failures++; $display("FAIL neg_dry: got %0d want -1001", res); end
        send_sample(0, res, lat);
        checks++; if (res !== -501) begin failures++; $display("FAIL neg_floor_shift1: got %0d want -501", res); end
        fb_shift = 3'd3;
        send_sample(0, res, lat);
        checks++; if (res !== -63) begin failures++; $display("FAIL neg_floor_shift3: got %0d want -63", res); end
        fb_shift = 3'd0;
        send_sample(100, res, lat);
        checks++; if (res !== 100) begin failures++; $display("FAIL wet_off: got %0d want 100", res); end
    endtask

    task automatic test_saturation();
        int res, lat;
        fresh_start();
        enable = 1'b1; delay_len = 4'd1; fb_shift = 3'd1;
        send_sample(2000, res, lat);
        checks++; if (res !== 2000) begin failures++; $display("FAIL sat_pos_prime: got %0d want 2000", res); end
        send_sample(2000, res, lat);
        checks++; if (res !== 2047) begin failures++; $display("FAIL sat_pos: got %0d want 2047", res); end
        fresh_start();
        send_sample(-2000, res, lat);
        checks++; if (res !== -2000) begin failures++; $display("FAIL sat_neg_prime: got %0d want -2000", res); end
        send_sample(-2000, res, lat);
        checks++; if (res !== -2048) begin failures++; $display("FAIL sat_neg: got %0d want -2048", res); end
    endtask

    task automatic test_wrap();
        int res, lat, bad_vals, bad_lat;
        fresh_start();
        enable = 1'b1; delay_len = 4'd0; fb_shift = 3'd2;
        send_sample(800, res, lat);
        checks++; if (res !== 800) begin failures++; $display("FAIL wrap_impulse: got %0d want 800", res); end
        bad_vals = 0;
        bad_lat  = 0;
        for (int i = 1; i <= 15; i++) begin
            send_sample(0, res, lat);
            if (res !== 0) bad_vals++;
            if (lat !== 2) bad_lat++;
        end
        checks++; if (bad_vals !== 0) begin failures++; $display("FAIL wrap_zeros: got %0d nonzero want 0", bad_vals); end
        checks++; if (bad_lat !== 0) begin failures++; $display("FAIL wrap_latency: got %0d late want 0", bad_lat); end
        send_sample(0, res, lat);
        checks++; if (res !== 200) begin failures++; $display("FAIL wrap_echo17: got %0d want 200", res); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL wrap_echo17_latency: got %0d want 2", lat); end
    endtask

    task automatic test_back_to_back_start();
        int dones, first_val;
        fresh_start();
        enable = 1'b0;
        dones = 0;
        first_val = 0;
        @(negedge clock);
        start = 1'b1;
        incoming_sample = 12'sh0AA;
        @(posedge clock);
        @(negedge clock);
        incoming_sample = 12'sh155;
        @(posedge clock);
        #1;
        if (done) dones++;
        @(negedge clock);
        start = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (done) begin
                dones++;
                if (dones == 1) first_val = modified_sample;
            end
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL read_start_ignored: got %0d dones want 1", dones); end
        checks++; if (first_val !== 12'h0AA) begin failures++; $display("FAIL read_start_value: got %0d want %0d", first_val, 12'h0AA); end
    endtask

    task automatic test_reset_in_mix();
        int res, lat, n, dones;
        fresh_start();
        enable = 1'b0;
        send_sample(12'h100, res, lat);
        checks++; if (res !== 12'h100) begin failures++; $display("FAIL pre_abort_value: got %0d want %0d", res, 12'h100); end
        @(negedge clock);
        start = 1'b1;
        incoming_sample = 12'sh2BC;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %0b want 0", done); end
        checks++; if (modified_sample !== 0) begin failures++; $display("FAIL abort_sample: got %0d want 0", modified_sample); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL abort_ready: got %0b want 0", ready); end
        @(negedge clock);
        reset = 1'b0;
        wait_ready(n, dones);
        checks++; if (n !== 16) begin failures++; $display("FAIL abort_clear_cycles: got %0d want 16", n); end
        checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        enable = 1'b0;
        delay_len = '0;
        fb_shift = 3'd0;
        incoming_sample = '0;
        test_reset();
        test_bypass();
        test_echo_chain();
        test_saturation();
        test_wrap();
        test_back_to_back_start();
        test_reset_in_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
